// File: rtl/redun_mont_pkg.sv
// Shared definitions for the redundant-form Montgomery datapath.
// Contents: word geometry, the redundant (redun0_t) and plain (fe_t) value
// types, conversions between them, and the squaring controller state type.
package redun_mont_pkg;

  localparam int WRD_BITS = 64;
  localparam int NUM_WRDS = 17;
  localparam int DAT_BITS = NUM_WRDS * WRD_BITS;
  localparam int RWD_BITS = WRD_BITS + 1;
  localparam int TOT_BITS = NUM_WRDS * RWD_BITS;
  localparam int T_LEN    = 64;
  localparam int IDX_BITS = $clog2(NUM_WRDS);

  localparam logic [T_LEN-1:0] T_ZERO  = {T_LEN{1'b0}};
  localparam logic [T_LEN-1:0] T_ONE   = {{(T_LEN-1){1'b0}}, 1'b1};
  localparam logic [31:0]      RSV_MAX = 32'hFFFF_FFFF;
  localparam logic [31:0]      RSV_ONE = 32'd1;

  // Redundant form: word i occupies [i*RWD_BITS +: RWD_BITS]; its top bit is
  // a pending carry into word i+1.
  typedef logic [TOT_BITS-1:0] redun0_t;
  typedef logic [DAT_BITS-1:0] fe_t;

  typedef enum logic [2:0] {
    SQ_IDLE    = 3'd0,
    SQ_ISSUE   = 3'd1,
    SQ_WAIT    = 3'd2,
    SQ_RESOLVE = 3'd3,
    SQ_DONE    = 3'd4
  } sq_state_t;

  // Spread a plain value into redundant words with every carry bit clear.
  function automatic redun0_t to_redun(input fe_t v);
    redun0_t r;
    r = {TOT_BITS{1'b0}};
    for (int i = 0; i < NUM_WRDS; i++) begin
      r[i*RWD_BITS +: RWD_BITS] = {1'b0, v[i*WRD_BITS +: WRD_BITS]};
    end
    return r;
  endfunction

  // Gather the low WRD_BITS of each word; only exact once carries are resolved.
  function automatic fe_t from_redun(input redun0_t r);
    fe_t v;
    v = {DAT_BITS{1'b0}};
    for (int i = 0; i < NUM_WRDS; i++) begin
      v[i*WRD_BITS +: WRD_BITS] = r[i*RWD_BITS +: WRD_BITS];
    end
    return v;
  endfunction

endpackage

// File: rtl/redun_carry_resolve.sv
// Word-serial carry normaliser for redundant values.
// Ports: clk/rst_n (sync active-low), start loads din and begins a pass,
// done is high during the last word cycle, dout presents the value including
// the word being resolved this cycle (fully normalised while done is high).
module redun_carry_resolve
  import redun_mont_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    start,
  input  redun0_t din,
  output logic    done,
  output redun0_t dout
);

  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_WRDS - 1);
  localparam logic [IDX_BITS-1:0] IDX_ONE  = {{(IDX_BITS-1){1'b0}}, 1'b1};

  redun0_t             work_r;
  redun0_t             work_nxt_s;
  logic [IDX_BITS-1:0] idx_r;
  logic [1:0]          carry_r;
  logic [1:0]          carry_nxt_s;
  logic                busy_r;
  logic [RWD_BITS-1:0] cur_wrd_s;
  logic [WRD_BITS+1:0] sum_s;

  // Resolve the current word; the carry can reach 2 when both the stored
  // carry bit and the add carry-out are set.
  always_comb begin
    work_nxt_s  = work_r;
    cur_wrd_s   = work_r[idx_r*RWD_BITS +: RWD_BITS];
    sum_s       = {2'b00, cur_wrd_s[WRD_BITS-1:0]} + {{WRD_BITS{1'b0}}, carry_r};
    carry_nxt_s = {1'b0, cur_wrd_s[WRD_BITS]} + sum_s[WRD_BITS+1:WRD_BITS];
    if (busy_r) begin
      work_nxt_s[idx_r*RWD_BITS +: RWD_BITS] = {1'b0, sum_s[WRD_BITS-1:0]};
    end else begin
      work_nxt_s = work_r;
    end
  end

  // Pass sequencing: load on start, then step one word per cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      work_r  <= {TOT_BITS{1'b0}};
      idx_r   <= {IDX_BITS{1'b0}};
      carry_r <= 2'b00;
      busy_r  <= 1'b0;
    end else if (start) begin
      work_r  <= din;
      idx_r   <= {IDX_BITS{1'b0}};
      carry_r <= 2'b00;
      busy_r  <= 1'b1;
    end else if (busy_r) begin
      work_r  <= work_nxt_s;
      carry_r <= carry_nxt_s;
      if (idx_r == LAST_IDX) begin
        busy_r <= 1'b0;
        idx_r  <= {IDX_BITS{1'b0}};
      end else begin
        idx_r <= idx_r + IDX_ONE;
      end
    end
  end

  assign done = busy_r && (idx_r == LAST_IDX);
  assign dout = work_nxt_s;

endmodule

// File: rtl/redun_mont_sq_ctrl.sv
// Sequencer for the redundant-form Montgomery squaring core.
// Ports: start handshake (i_start_val/o_start_rdy, i_sq, i_t); core issue
// (o_core_val pulse, o_core_dat operand); core return (i_core_val,
// i_core_dat, i_core_spec_carry); result handshake (o_res_val/i_res_rdy,
// o_res); status (o_iter, o_resolve_cnt, sticky o_err).
module redun_mont_sq_ctrl
  import redun_mont_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start_val,
  output logic                o_start_rdy,
  input  logic [DAT_BITS-1:0] i_sq,
  input  logic [T_LEN-1:0]    i_t,
  output logic                o_core_val,
  output logic [TOT_BITS-1:0] o_core_dat,
  input  logic                i_core_val,
  input  logic [TOT_BITS-1:0] i_core_dat,
  input  logic                i_core_spec_carry,
  output logic                o_res_val,
  input  logic                i_res_rdy,
  output logic [DAT_BITS-1:0] o_res,
  output logic [T_LEN-1:0]    o_iter,
  output logic [31:0]         o_resolve_cnt,
  output logic                o_err
);

  sq_state_t        state_r;
  sq_state_t        state_nxt_s;
  redun0_t          x_r;
  redun0_t          x_nxt_s;
  redun0_t          core_dat_r;
  fe_t              res_r;
  logic [T_LEN-1:0] cnt_r;
  logic [T_LEN-1:0] cnt_nxt_s;
  logic [T_LEN-1:0] iter_r;
  logic [T_LEN-1:0] iter_nxt_s;
  logic [31:0]      rsv_cnt_r;
  logic [31:0]      rsv_cnt_nxt_s;
  logic             start_rdy_r;
  logic             core_val_r;
  logic             res_val_r;
  logic             err_r;
  logic             rs_start_s;
  logic             rs_done_s;
  redun0_t          rs_dout_s;

  // The resolver is loaded straight from the core result that triggers it.
  redun_carry_resolve u_resolve (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .start (rs_start_s),
    .din   (i_core_dat),
    .done  (rs_done_s),
    .dout  (rs_dout_s)
  );

  // Next-state and datapath updates for the squaring sequence.
  always_comb begin
    state_nxt_s   = state_r;
    x_nxt_s       = x_r;
    cnt_nxt_s     = cnt_r;
    iter_nxt_s    = iter_r;
    rsv_cnt_nxt_s = rsv_cnt_r;
    rs_start_s    = 1'b0;
    case (state_r)
      SQ_IDLE: begin
        if (i_start_val) begin
          x_nxt_s       = to_redun(i_sq);
          cnt_nxt_s     = i_t;
          iter_nxt_s    = T_ZERO;
          rsv_cnt_nxt_s = 32'd0;
          state_nxt_s   = (i_t == T_ZERO) ? SQ_DONE : SQ_ISSUE;
        end else begin
          state_nxt_s = SQ_IDLE;
        end
      end
      SQ_ISSUE: begin
        state_nxt_s = SQ_WAIT;
      end
      SQ_WAIT: begin
        if (i_core_val) begin
          x_nxt_s    = i_core_dat;
          cnt_nxt_s  = cnt_r - T_ONE;
          iter_nxt_s = iter_r + T_ONE;
          // The final square is always normalised before it is returned.
          if (i_core_spec_carry || (cnt_r == T_ONE)) begin
            state_nxt_s = SQ_RESOLVE;
            rs_start_s  = 1'b1;
          end else begin
            state_nxt_s = SQ_ISSUE;
          end
        end else begin
          state_nxt_s = SQ_WAIT;
        end
      end
      SQ_RESOLVE: begin
        if (rs_done_s) begin
          x_nxt_s = rs_dout_s;
          if (rsv_cnt_r != RSV_MAX) begin
            rsv_cnt_nxt_s = rsv_cnt_r + RSV_ONE;
          end else begin
            rsv_cnt_nxt_s = rsv_cnt_r;
          end
          state_nxt_s = (cnt_r == T_ZERO) ? SQ_DONE : SQ_ISSUE;
        end else begin
          state_nxt_s = SQ_RESOLVE;
        end
      end
      SQ_DONE: begin
        if (i_res_rdy) begin
          state_nxt_s = SQ_IDLE;
        end else begin
          state_nxt_s = SQ_DONE;
        end
      end
      default: begin
        state_nxt_s = SQ_IDLE;
      end
    endcase
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_r     <= SQ_IDLE;
      x_r         <= {TOT_BITS{1'b0}};
      core_dat_r  <= {TOT_BITS{1'b0}};
      res_r       <= {DAT_BITS{1'b0}};
      cnt_r       <= T_ZERO;
      iter_r      <= T_ZERO;
      rsv_cnt_r   <= 32'd0;
      start_rdy_r <= 1'b1;
      core_val_r  <= 1'b0;
      res_val_r   <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      x_r         <= x_nxt_s;
      cnt_r       <= cnt_nxt_s;
      iter_r      <= iter_nxt_s;
      rsv_cnt_r   <= rsv_cnt_nxt_s;
      start_rdy_r <= (state_nxt_s == SQ_IDLE);
      core_val_r  <= (state_nxt_s == SQ_ISSUE);
      res_val_r   <= (state_nxt_s == SQ_DONE);
      // Operand is captured on entry to ISSUE and held until the next issue.
      if (state_nxt_s == SQ_ISSUE) begin
        core_dat_r <= x_nxt_s;
      end
      // Result is captured once on entry to DONE so it stays stable while stalled.
      if ((state_nxt_s == SQ_DONE) && (state_r != SQ_DONE)) begin
        res_r <= from_redun(x_nxt_s);
      end
      if (i_core_val && (state_r != SQ_WAIT)) begin
        err_r <= 1'b1;
      end
    end
  end

  assign o_start_rdy   = start_rdy_r;
  assign o_core_val    = core_val_r;
  assign o_core_dat    = core_dat_r;
  assign o_res_val     = res_val_r;
  assign o_res         = res_r;
  assign o_iter        = iter_r;
  assign o_resolve_cnt = rsv_cnt_r;
  assign o_err         = err_r;

endmodule

// File: tb/tb_redun_mont_sq_ctrl.sv
// Self-checking bench for redun_mont_sq_ctrl with a behavioural squaring core.
module tb_redun_mont_sq_ctrl;

  localparam int W   = 64;
  localparam int N   = 17;
  localparam int RW  = 65;
  localparam int DB  = 1088;
  localparam int TB  = 1105;
  localparam int TL  = 64;
  localparam int LAT = 4;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_start_val = 1'b0;
  logic          o_start_rdy;
  logic [DB-1:0] i_sq = '0;
  logic [TL-1:0] i_t = '0;
  logic          o_core_val;
  logic [TB-1:0] o_core_dat;
  logic          i_core_val = 1'b0;
  logic [TB-1:0] i_core_dat = '0;
  logic          i_core_spec_carry = 1'b0;
  logic          o_res_val;
  logic          i_res_rdy = 1'b0;
  logic [DB-1:0] o_res;
  logic [TL-1:0] o_iter;
  logic [31:0]   o_resolve_cnt;
  logic          o_err;

  always #5 i_clk = ~i_clk;

  redun_mont_sq_ctrl dut (
    .i_clk             (i_clk),
    .i_rst_n           (i_rst_n),
    .i_start_val       (i_start_val),
    .o_start_rdy       (o_start_rdy),
    .i_sq              (i_sq),
    .i_t               (i_t),
    .o_core_val        (o_core_val),
    .o_core_dat        (o_core_dat),
    .i_core_val        (i_core_val),
    .i_core_dat        (i_core_dat),
    .i_core_spec_carry (i_core_spec_carry),
    .o_res_val         (o_res_val),
    .i_res_rdy         (i_res_rdy),
    .o_res             (o_res),
    .o_iter            (o_iter),
    .o_resolve_cnt     (o_resolve_cnt),
    .o_err             (o_err)
  );

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  logic [TB-1:0] exp_ops[$];
  logic [DB-1:0] exp_res = '0;
  logic [TL-1:0] exp_t = '0;
  logic [31:0]   exp_passes = '0;
  logic          exp_err = 1'b0;
  int            issue_cnt = 0;
  int            last_core_cyc = 0;
  int            first_res_cyc = 0;
  logic          prev_res_val = 1'b0;
  int            pend = 0;
  int            mode = 0;
  logic          inj_pending = 1'b0;
  logic          inj_flag = 1'b0;
  logic [TB-1:0] resp_dat = '0;
  logic          resp_spec = 1'b0;
  logic [TB-1:0] pat = '0;

  function automatic logic [TB-1:0] pack(input logic [DB-1:0] v);
    logic [TB-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[i*RW +: RW] = {1'b0, v[i*W +: W]};
    return r;
  endfunction

  function automatic logic [DB-1:0] unpack(input logic [TB-1:0] r);
    logic [DB-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i*W +: W] = r[i*RW +: W];
    return v;
  endfunction

  function automatic logic [DB-1:0] sq_trunc(input logic [DB-1:0] v);
    logic [2*DB-1:0] p;
    p = {{DB{1'b0}}, v} * {{DB{1'b0}}, v};
    return p[DB-1:0];
  endfunction

  task automatic chk(input string nm, input logic [TB-1:0] act, input logic [TB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act[255:0], exp[255:0], cyc);
    end
  endtask

  // One clock: per-cycle comparison against the model, then the core responder.
  task automatic tick();
    logic rst_s, cv_s, inj_s;
    @(posedge i_clk);
    rst_s = i_rst_n;
    cv_s  = i_core_val;
    inj_s = inj_flag;
    cyc++;
    #1;
    if (!rst_s) begin
      exp_err = 1'b0;
      pend = 0;
      chk("rst_start_rdy", TB'(o_start_rdy), TB'(1'b1));
      chk("rst_core_val", TB'(o_core_val), TB'(1'b0));
      chk("rst_core_dat", o_core_dat, TB'(1'b0));
      chk("rst_res_val", TB'(o_res_val), TB'(1'b0));
      chk("rst_res", TB'(o_res), TB'(1'b0));
      chk("rst_iter", TB'(o_iter), TB'(1'b0));
      chk("rst_resolve_cnt", TB'(o_resolve_cnt), TB'(1'b0));
      chk("rst_err", TB'(o_err), TB'(1'b0));
    end else begin
      if (cv_s && inj_s) exp_err = 1'b1;
      if (cv_s && !inj_s) last_core_cyc = cyc;
      chk("err", TB'(o_err), TB'(exp_err));
      chk("rdy_vs_res_val", TB'(o_start_rdy & o_res_val), TB'(1'b0));
      if (o_core_val) begin
        issue_cnt++;
        if (exp_ops.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL core_issue: got unexpected issue pulse, required none (cycle %0d)", cyc);
        end else begin
          chk("core_dat", o_core_dat, exp_ops.pop_front());
        end
      end
      if (o_res_val) begin
        if (!prev_res_val) first_res_cyc = cyc;
        chk("res", TB'(o_res), TB'(exp_res));
        chk("iter", TB'(o_iter), TB'(exp_t));
        chk("resolve_cnt", TB'(o_resolve_cnt), TB'(exp_passes));
      end
    end
    prev_res_val = o_res_val;
    // Behavioural core: fixed latency, one operation in flight.
    i_core_val        = 1'b0;
    i_core_spec_carry = 1'b0;
    i_core_dat        = '0;
    inj_flag          = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        i_core_val        = 1'b1;
        i_core_dat        = resp_dat;
        i_core_spec_carry = resp_spec;
      end
    end
    if (inj_pending) begin
      i_core_val  = 1'b1;
      inj_flag    = 1'b1;
      inj_pending = 1'b0;
    end
    if (o_core_val && rst_s) begin
      pend = LAT - 1;
      if (mode == 0) begin
        resp_dat  = pack(sq_trunc(unpack(o_core_dat)));
        resp_spec = 1'b0;
      end else begin
        resp_dat  = pat;
        resp_spec = 1'b1;
      end
    end
  endtask

  // Plain squaring model: operands issued and final value of x^(2^t).
  task automatic model_sq(input logic [DB-1:0] sq, input int t);
    logic [DB-1:0] v;
    v = sq;
    exp_ops.delete();
    for (int k = 0; k < t; k++) begin
      exp_ops.push_back(pack(v));
      v = sq_trunc(v);
    end
    exp_res    = v;
    exp_t      = TL'(t);
    exp_passes = (t == 0) ? 32'd0 : 32'd1;
  endtask

  task automatic start_job(input logic [DB-1:0] sq, input int t);
    issue_cnt = 0;
    for (int i = 0; i < 50 && !o_start_rdy; i++) tick();
    chk("start_rdy_seen", TB'(o_start_rdy), TB'(1'b1));
    i_sq        = sq;
    i_t         = TL'(t);
    i_start_val = 1'b1;
    tick();
    i_start_val = 1'b0;
  endtask

  task automatic wait_res();
    for (int i = 0; i < 3000 && !o_res_val; i++) tick();
    chk("res_val_seen", TB'(o_res_val), TB'(1'b1));
  endtask

  task automatic accept();
    i_res_rdy = 1'b1;
    tick();
    i_res_rdy = 1'b0;
    chk("res_val_drop", TB'(o_res_val), TB'(1'b0));
    chk("idle_after_rdy", TB'(o_start_rdy), TB'(1'b1));
  endtask

  initial begin
    logic [DB-1:0] held;
    logic [TB-1:0] rop;
    logic [DB-1:0] lit;

    pat = '0;
    pat[64:0]   = 65'h1_0000_0000_0000_0003;
    pat[129:65] = 65'h0_FFFF_FFFF_FFFF_FFFF;

    tick();
    tick();
    i_rst_n = 1'b1;
    tick();

    // t = 0: result straight back, no issues.
    model_sq(1088'h1234, 0);
    start_job(1088'h1234, 0);
    chk("t0_res_val_next_cycle", TB'(o_res_val), TB'(1'b1));
    chk("t0_res_lit", TB'(o_res), TB'(16'h1234));
    accept();
    chk("t0_issues", TB'(issue_cnt), TB'(0));

    // t = 3 squarings of 5, then a 10-cycle stall in DONE.
    model_sq(1088'd5, 3);
    start_job(1088'd5, 3);
    wait_res();
    chk("t3_res_lit", TB'(o_res), TB'(32'd390625));
    chk("t3_iter_lit", TB'(o_iter), TB'(3));
    chk("t3_resolve_lit", TB'(o_resolve_cnt), TB'(1));
    chk("t3_issues", TB'(issue_cnt), TB'(3));
    chk("resolve_latency", TB'(first_res_cyc - last_core_cyc), TB'(N));
    held = o_res;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_res_stable", TB'(o_res), TB'(held));
      chk("hold_res_val", TB'(o_res_val), TB'(1'b1));
      chk("hold_start_rdy", TB'(o_start_rdy), TB'(1'b0));
    end
    accept();

    // Speculative carries on every result: two resolve passes.
    mode = 1;
    exp_ops.delete();
    exp_ops.push_back(pack(1088'd7));
    rop = '0;
    rop[64:0]    = 65'd3;
    rop[194:130] = 65'd1;
    exp_ops.push_back(rop);
    lit = '0;
    lit[63:0] = 64'd3;
    lit[128]  = 1'b1;
    exp_res    = lit;
    exp_t      = TL'(2);
    exp_passes = 32'd2;
    start_job(1088'd7, 2);
    wait_res();
    chk("carry_issues", TB'(issue_cnt), TB'(2));
    chk("carry_resolve_lit", TB'(o_resolve_cnt), TB'(2));
    accept();
    mode = 0;

    // Reset in WAIT of a t = 5 job, then a clean t = 1 job.
    model_sq(1088'd3, 5);
    start_job(1088'd3, 5);
    for (int i = 0; i < 20 && issue_cnt < 1; i++) tick();
    chk("rst_job_issued", TB'(issue_cnt), TB'(1));
    tick();
    i_rst_n = 1'b0;
    tick();
    i_rst_n = 1'b1;
    exp_ops.delete();
    tick();
    model_sq(1088'd9, 1);
    start_job(1088'd9, 1);
    wait_res();
    chk("after_rst_res_lit", TB'(o_res), TB'(8'd81));
    accept();

    // Stray core result in IDLE sets the sticky error.
    inj_pending = 1'b1;
    tick();
    tick();
    chk("err_set", TB'(o_err), TB'(1'b1));
    model_sq(1088'd11, 1);
    start_job(1088'd11, 1);
    wait_res();
    chk("err_job_res_lit", TB'(o_res), TB'(8'd121));
    accept();
    chk("err_sticky", TB'(o_err), TB'(1'b1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
